// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch/jump redirect and load-use hazard controller
//
// Purpose: stalls a conditional branch in ID while an older instruction is
//   still producing one of its source operands, captures the target of a
//   taken branch or jump, and issues a one-cycle redirect that flushes the
//   wrong-path fetch. A global hold freezes everything; a trap flush
//   overrides everything and cancels any pending redirect.
//
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   id_is_branch_i, id_is_jump_i   branch / JAL in ID
//   id_rs1_i, id_rs2_i             branch source registers
//   ex_reg_write_i, ex_mem_read_i  EX producer writes rd / is a load
//   ex_rd_i                        EX destination register
//   mem_mem_read_i, mem_rd_i       MEM load and its destination register
//   br_taken_i, br_target_i        comparator result and target
//   pipe_hold_i, trap_flush_i      pipeline freeze, trap redirect
//   pc_write_o, ifid_write_o       PC / IF-ID write enables
//   ifid_flush_o, idex_bubble_o    zero IF-ID, inject NOP into ID-EX
//   pc_sel_o, pc_target_o          select redirect target, registered target
//   taken_cnt_o, stall_cnt_o       statistics (only with BRANCH_STATS_EN)
//
// Configuration macro: BRANCH_STATS_EN adds the saturating statistics counters.

module branch_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            id_is_branch_i,
    input  logic            id_is_jump_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic            ex_reg_write_i,
    input  logic            ex_mem_read_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            mem_mem_read_i,
    input  logic [4:0]      mem_rd_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            pipe_hold_i,
    input  logic            trap_flush_i,
    output logic            pc_write_o,
    output logic            ifid_write_o,
    output logic            ifid_flush_o,
    output logic            idex_bubble_o,
    output logic            pc_sel_o,
    output logic [XLEN-1:0] pc_target_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     taken_cnt_o,
    output logic [31:0]     stall_cnt_o
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t state, next_state;

    logic ex_match;
    logic mem_match;
    logic hazard;
    logic take;
    logic capture;
    logic stall;

    // x0 is hardwired to zero, so it can never carry a pending result.
    assign ex_match  = (ex_rd_i != 5'd0) && ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    assign mem_match = (mem_rd_i != 5'd0) && ((mem_rd_i == id_rs1_i) || (mem_rd_i == id_rs2_i));

    // The comparator sits in ID, so any EX producer is too late; a load in MEM
    // is too late as well, while an ALU result in MEM is forwarded in time.
    assign hazard = id_is_branch_i &&
                    (((ex_mem_read_i || ex_reg_write_i) && ex_match) ||
                     (mem_mem_read_i && mem_match));

    assign take = (id_is_branch_i && br_taken_i) || id_is_jump_i;

    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pc_sel_o      = 1'b0;
        next_state    = state;
        capture       = 1'b0;
        stall         = 1'b0;

        if (!rst_n_i) begin
            // Outputs held at zero while in reset.
            next_state = IDLE;
        end else if (trap_flush_i) begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            next_state    = IDLE;
        end else if (pipe_hold_i) begin
            // Freeze: state and captured target retained.
        end else if (state == REDIRECT) begin
            // ID holds a wrong-path instruction; its branch/jump flags are ignored.
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            pc_sel_o      = 1'b1;
            next_state    = IDLE;
        end else if (hazard) begin
            idex_bubble_o = 1'b1;
            stall         = 1'b1;
        end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            if (take) begin
                capture    = 1'b1;
                next_state = REDIRECT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            pc_target_o <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                pc_target_o <= br_target_i;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // capture and stall are already suppressed by hold and trap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            taken_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (capture && (taken_cnt_o != 32'hFFFF_FFFF)) begin
                taken_cnt_o <= taken_cnt_o + 32'd1;
            end
            if (stall && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl
module tb_branch_ctrl;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            id_is_branch_i, id_is_jump_i;
    logic [4:0]      id_rs1_i, id_rs2_i;
    logic            ex_reg_write_i, ex_mem_read_i;
    logic [4:0]      ex_rd_i;
    logic            mem_mem_read_i;
    logic [4:0]      mem_rd_i;
    logic            br_taken_i;
    logic [XLEN-1:0] br_target_i;
    logic            pipe_hold_i, trap_flush_i;
    logic            pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pc_sel_o;
    logic [XLEN-1:0] pc_target_o;
`ifdef BRANCH_STATS_EN
    logic [31:0]     taken_cnt_o, stall_cnt_o;
`endif

    branch_ctrl #(.XLEN(XLEN)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .id_is_branch_i (id_is_branch_i),
        .id_is_jump_i   (id_is_jump_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .ex_reg_write_i (ex_reg_write_i),
        .ex_mem_read_i  (ex_mem_read_i),
        .ex_rd_i        (ex_rd_i),
        .mem_mem_read_i (mem_mem_read_i),
        .mem_rd_i       (mem_rd_i),
        .br_taken_i     (br_taken_i),
        .br_target_i    (br_target_i),
        .pipe_hold_i    (pipe_hold_i),
        .trap_flush_i   (trap_flush_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .pc_sel_o       (pc_sel_o),
        .pc_target_o    (pc_target_o)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt_o    (taken_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel}
    wire [4:0] outs = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pc_sel_o};

    localparam logic [4:0] O_NORM  = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_TRAP  = 5'b11110;
    localparam logic [4:0] O_REDIR = 5'b11111;
    localparam logic [4:0] O_ZERO  = 5'b00000;

    typedef struct {
        logic        br, jmp;
        logic [4:0]  rs1, rs2;
        logic        ex_rw, ex_mr;
        logic [4:0]  ex_rd;
        logic        mem_mr;
        logic [4:0]  mem_rd;
        logic        tk;
        logic [31:0] tgt;
        logic        hold, trap;
        logic [4:0]  exp_out;
        logic        exp_redir;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        id_is_branch_i = v.br;
        id_is_jump_i   = v.jmp;
        id_rs1_i       = v.rs1;
        id_rs2_i       = v.rs2;
        ex_reg_write_i = v.ex_rw;
        ex_mem_read_i  = v.ex_mr;
        ex_rd_i        = v.ex_rd;
        mem_mem_read_i = v.mem_mr;
        mem_rd_i       = v.mem_rd;
        br_taken_i     = v.tk;
        br_target_i    = v.tgt;
        pipe_hold_i    = v.hold;
        trap_flush_i   = v.trap;
    endtask

    function automatic vec_t mk(input logic br, jmp, input logic [4:0] rs1, rs2,
                                input logic ex_rw, ex_mr, input logic [4:0] ex_rd,
                                input logic mem_mr, input logic [4:0] mem_rd,
                                input logic tk, input logic [31:0] tgt,
                                input logic hold, trap,
                                input logic [4:0] eo, input logic er);
        vec_t v;
        v.br = br; v.jmp = jmp; v.rs1 = rs1; v.rs2 = rs2;
        v.ex_rw = ex_rw; v.ex_mr = ex_mr; v.ex_rd = ex_rd;
        v.mem_mr = mem_mr; v.mem_rd = mem_rd; v.tk = tk; v.tgt = tgt;
        v.hold = hold; v.trap = trap; v.exp_out = eo; v.exp_redir = er;
        return v;
    endfunction

    vec_t neutral_v;
    vec_t vecs[13];
    vec_t v;

    task automatic neutral();
        drive(neutral_v);
    endtask

    // Drive at the falling edge, sample 2 ns later, well away from the rising edge.
    task automatic step_drive(input vec_t x);
        @(negedge clk_i);
        drive(x);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        neutral();
        rst_n_i = 1'b0;
        #2;
        chk("reset_outs", outs, O_ZERO);
        chk("reset_target", pc_target_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        neutral_v = mk(0,0,0,0, 0,0,0, 0,0, 0,32'h0, 0,0, O_NORM,0);
        //               br jmp rs1 rs2 exrw exmr exrd memmr memrd tk tgt           hold trap exp     redir
        vecs[0]  = mk(0,0, 1,2,  0,0,0,  0,0,  0,32'h0,        0,0, O_NORM, 0);
        vecs[1]  = mk(1,0, 5,6,  0,1,5,  0,0,  0,32'h0,        0,0, O_STALL,0);
        vecs[2]  = mk(1,0, 4,5,  1,0,5,  0,0,  1,32'h40,       0,0, O_STALL,0);
        vecs[3]  = mk(1,0, 7,8,  0,0,0,  1,7,  0,32'h0,        0,0, O_STALL,0);
        vecs[4]  = mk(1,0, 3,0,  1,0,0,  0,0,  0,32'h0,        0,0, O_NORM, 0);
        vecs[5]  = mk(1,0, 9,10, 0,0,0,  0,9,  0,32'h0,        0,0, O_NORM, 0);
        vecs[6]  = mk(1,0, 1,2,  0,0,0,  0,0,  1,32'h100,      0,0, O_NORM, 1);
        vecs[7]  = mk(0,1, 5,6,  0,1,5,  0,0,  0,32'hABC,      0,0, O_NORM, 1);
        vecs[8]  = mk(1,0, 1,2,  0,0,0,  0,0,  1,32'h200,      1,0, O_ZERO, 0);
        vecs[9]  = mk(1,0, 1,2,  0,0,0,  0,0,  1,32'h300,      0,1, O_TRAP, 0);
        vecs[10] = mk(1,0, 1,2,  0,0,0,  0,0,  1,32'h300,      1,1, O_TRAP, 0);
        vecs[11] = mk(0,0, 5,6,  1,1,5,  1,6,  0,32'h0,        0,0, O_NORM, 0);
        vecs[12] = mk(1,0, 4,6,  1,1,3,  1,3,  1,32'hDEAD_BEE0,0,0, O_NORM, 1);

        neutral();
        rst_n_i = 1'b0;
        #2;
        chk("reset_outs0", outs, O_ZERO);
        chk("reset_target0", pc_target_o, 0);
`ifdef BRANCH_STATS_EN
        chk("reset_taken_cnt", taken_cnt_o, 0);
        chk("reset_stall_cnt", stall_cnt_o, 0);
`endif
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 13; i++) begin
            logic [31:0] tgt_before;
            tgt_before = pc_target_o;
            step_drive(vecs[i]);
            chk($sformatf("vec%0d_outs", i), outs, vecs[i].exp_out);
            step_drive(neutral_v);
            if (vecs[i].exp_redir) begin
                chk($sformatf("vec%0d_redir", i), outs, O_REDIR);
                chk($sformatf("vec%0d_target", i), pc_target_o, vecs[i].tgt);
            end else begin
                chk($sformatf("vec%0d_idle", i), outs, O_NORM);
                chk($sformatf("vec%0d_keep", i), pc_target_o, tgt_before);
            end
        end

        // Load-use: load in EX then MEM gives exactly two stall cycles.
        do_reset();
        step_drive(mk(1,0,5,0, 0,1,5, 0,0, 0,0, 0,0, O_STALL,0));
        chk("lu_stall1", outs, O_STALL);
        step_drive(mk(1,0,5,0, 0,0,0, 1,5, 0,0, 0,0, O_STALL,0));
        chk("lu_stall2", outs, O_STALL);
        step_drive(mk(1,0,5,0, 0,0,0, 0,0, 0,0, 0,0, O_NORM,0));
        chk("lu_release", outs, O_NORM);
`ifdef BRANCH_STATS_EN
        chk("lu_stall_cnt", stall_cnt_o, 2);
`endif

        // Taken branch; wrong-path hazard during REDIRECT is ignored.
        step_drive(mk(1,0,1,2, 0,0,0, 0,0, 1,32'h100, 0,0, O_NORM,0));
        chk("tb_issue", outs, O_NORM);
        step_drive(mk(1,0,5,0, 0,1,5, 0,0, 1,32'h200, 0,0, O_NORM,0));
        chk("tb_redir", outs, O_REDIR);
        chk("tb_target", pc_target_o, 32'h100);
        step_drive(neutral_v);
        chk("tb_back_idle", outs, O_NORM);
        chk("tb_no_capture", pc_target_o, 32'h100);
`ifdef BRANCH_STATS_EN
        chk("tb_taken_cnt", taken_cnt_o, 1);
`endif

        // Taken branch followed by a three-cycle hold.
        step_drive(mk(1,0,1,2, 0,0,0, 0,0, 1,32'h200, 0,0, O_NORM,0));
        for (int k = 0; k < 3; k++) begin
            step_drive(mk(0,0,0,0, 1,1,5, 0,0, 0,32'h0, 1,0, O_ZERO,0));
            chk($sformatf("hold%0d_outs", k), outs, O_ZERO);
            chk($sformatf("hold%0d_target", k), pc_target_o, 32'h200);
        end
        step_drive(neutral_v);
        chk("hold_release_redir", outs, O_REDIR);
        chk("hold_release_target", pc_target_o, 32'h200);
        step_drive(neutral_v);
        chk("hold_after_idle", outs, O_NORM);
`ifdef BRANCH_STATS_EN
        chk("hold_taken_cnt", taken_cnt_o, 2);
        chk("hold_stall_cnt", stall_cnt_o, 2);
`endif

        // Taken branch together with trap: trap wins, no capture.
        step_drive(mk(1,0,1,2, 0,0,0, 0,0, 1,32'h300, 0,1, O_TRAP,0));
        chk("trap_br_outs", outs, O_TRAP);
        step_drive(neutral_v);
        chk("trap_br_no_redir", outs, O_NORM);
        chk("trap_br_target", pc_target_o, 32'h200);

        // Trap during REDIRECT cancels it.
        step_drive(mk(0,1,0,0, 0,0,0, 0,0, 0,32'h400, 0,0, O_NORM,0));
        step_drive(mk(0,0,0,0, 0,0,0, 0,0, 0,32'h0, 0,1, O_TRAP,0));
        chk("trap_redir_outs", outs, O_TRAP);
        step_drive(neutral_v);
        chk("trap_redir_idle", outs, O_NORM);

        // Reset asserted in REDIRECT.
        step_drive(mk(1,0,1,2, 0,0,0, 0,0, 1,32'h500, 0,0, O_NORM,0));
        step_drive(neutral_v);
        chk("rst_pre_redir", outs, O_REDIR);
        rst_n_i = 1'b0;
        #1;
        chk("rst_async_outs", outs, O_ZERO);
        chk("rst_async_target", pc_target_o, 0);
`ifdef BRANCH_STATS_EN
        chk("rst_async_taken_cnt", taken_cnt_o, 0);
`endif
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #2;
        chk("rst_release_idle", outs, O_NORM);
        step_drive(neutral_v);
        chk("rst_after_edge", outs, O_NORM);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter XLEN, 32: width of the branch target and PC redirect path.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  asynchronous, active-low reset.
REQ-004 id_is_branch_i  input  1  conditional branch in ID; the comparator result is valid this cycle.
REQ-005 id_is_jump_i  input  1  JAL in ID; always taken; no operand hazard check.
REQ-006 id_rs1_i, id_rs2_i  input  5 each  branch source registers in ID.
REQ-007 ex_reg_write_i, ex_mem_read_i  input  1 each  EX-stage instruction writes rd / is a load.
REQ-008 ex_rd_i  input  5  EX-stage destination register.
REQ-009 mem_mem_read_i  input  1  MEM-stage instruction is a load.
REQ-010 mem_rd_i  input  5  MEM-stage destination register.
REQ-011 br_taken_i  input  1  branch comparator taken output.
REQ-012 br_target_i  input  XLEN  branch/jump target computed in ID.
REQ-013 pipe_hold_i  input  1  global pipeline freeze, e.g. a multi-cycle EX unit.
REQ-014 trap_flush_i  input  1  trap/exception redirect request from the CSR unit.
REQ-015 pc_write_o, ifid_write_o  output  1 each  PC and IF/ID register write enables.
REQ-016 ifid_flush_o, idex_bubble_o  output  1 each  zero IF/ID; inject a NOP into ID/EX.
REQ-017 pc_sel_o  output  1  1 selects pc_target_o as next PC.
REQ-018 pc_target_o  output  XLEN  registered redirect target.

Function
REQ-019 States: IDLE, REDIRECT; state and the target register are the only control flops apart from the counters of REQ-032.
REQ-020 Match rule: a register matches when it is nonzero and equal to id_rs1_i or id_rs2_i; x0 never matches.
REQ-021 Hazard in IDLE with id_is_branch_i=1:
- ex_mem_read_i with an ex_rd_i match, or
- ex_reg_write_i with an ex_rd_i match, or
- mem_mem_read_i with a mem_rd_i match.
REQ-022 Hazard response, same cycle (combinational):
- pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, pc_sel_o=0.
- State remains IDLE; the hazard is re-evaluated every cycle.
- A load in EX therefore yields exactly 2 stall cycles; an ALU producer in EX yields 1.
REQ-023 No hazard in IDLE, with (id_is_branch_i and br_taken_i) or id_is_jump_i:
- Capture br_target_i into pc_target_o.
- Go to REDIRECT next cycle.
- Outputs this cycle are the normal values of REQ-024.
REQ-024 Normal IDLE outputs: pc_write_o=1, ifid_write_o=1, all other outputs 0.
REQ-025 REDIRECT lasts one cycle, then returns to IDLE:
- pc_sel_o=1, pc_write_o=1, ifid_flush_o=1, idex_bubble_o=1, ifid_write_o=1.
- Taken-branch penalty is exactly 2 cycles.
REQ-026 In REDIRECT, id_is_branch_i and id_is_jump_i are ignored (wrong-path) and produce no hazard or capture.
REQ-027 pipe_hold_i=1 (priority over REQ-021..026):
- All outputs 0 except pc_target_o.
- State and pc_target_o retained.
- A pending REDIRECT issues in the first cycle after the hold is released.
REQ-028 trap_flush_i=1 (highest priority, overrides hold):
- ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1, pc_sel_o=0, ifid_write_o=1.
- Next state IDLE; any pending redirect is cancelled.
REQ-029 Simultaneous branch taken and trap_flush_i: the trap wins and no capture occurs.

Reset
REQ-030 rst_n_i=0 asynchronously forces state IDLE, pc_target_o=0, and statistics counters to 0.
REQ-031 While rst_n_i=0, all other outputs SHALL be 0; normal IDLE operation starts on the first rising edge after rst_n_i deasserts.

Configuration
REQ-032 Macro BRANCH_STATS_EN defined:
- Adds outputs taken_cnt_o[31:0], counting REDIRECT entries, and stall_cnt_o[31:0], counting REQ-022 stall cycles.
- Both counters saturate at 32'hFFFFFFFF and do not count while pipe_hold_i=1.
REQ-033 Macro BRANCH_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Verification
REQ-034 Load in EX with rd=x5, branch in ID with rs1=x5 -> idex_bubble_o=1 and pc_write_o=0 for exactly 2 cycles; stall_cnt_o=2.
REQ-035 Branch in ID with rs2=x0 and ex_rd_i=x0, ex_reg_write_i=1 -> no stall.
REQ-036 Taken branch, target 32'h0000_0100, no hazard -> next cycle pc_sel_o=1, pc_target_o=32'h100, ifid_flush_o=1; then IDLE; taken_cnt_o=1.
REQ-037 Taken branch, then pipe_hold_i=1 for 3 cycles -> outputs 0 during the hold; REDIRECT to the captured target in the cycle after release.
REQ-038 Taken branch together with trap_flush_i=1 -> pc_sel_o stays 0 and no REDIRECT occurs; rst_n_i pulsed in REDIRECT -> all outputs 0 immediately, IDLE after release.
